timer_counter: RTL and testbench
================================

TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL have parameter NUM_BITS, default 16: counter and threshold width.
REQ-002 SHALL have parameter PRESC_BITS, default 8: prescaler width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk_i  in  1  clock; all state updates on rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 ctrl_active_i  in  1  counting enable; low freezes all counting state.
REQ-007 ctrl_update_i  in  1  load shadow config and restart the count.
REQ-008 ctrl_rst_i  in  1  restart the count with the current config.
REQ-009 tick_i  in  1  input event; one count credit per high cycle.
REQ-010 cfg_start_i  in  NUM_BITS  period start value.
REQ-011 cfg_end_i  in  NUM_BITS  period end value.
REQ-012 cfg_presc_i  in  PRESC_BITS  ticks per step, minus 1.
REQ-013 cfg_sawtooth_i  in  1  1 = sawtooth mode, 0 = up/down triangle mode.
REQ-014 counter_o  out  NUM_BITS  current count.
REQ-015 valid_o  out  1  one-cycle pulse: counter_o just stepped.
REQ-016 end_o  out  1  one-cycle pulse, coincident with valid_o: period boundary.
REQ-017 sawtooth_o  out  1  registered mode bit, for downstream comparators.

Function
REQ-018 Shadow regs r_start, r_end, r_presc, r_sawtooth SHALL load from cfg_* on the cycle ctrl_update_i is high.
- The same edge: counter_o <= cfg_start_i, direction = up, prescaler = 0.
REQ-019 Control priority SHALL be rst_i > ctrl_rst_i > ctrl_update_i > counting.
REQ-020 ctrl_rst_i SHALL do the following:
- counter_o <= r_start, direction = up, prescaler = 0.
- Shadow regs unchanged.
REQ-021 A qualified tick is ctrl_active_i & tick_i. The prescaler SHALL count qualified ticks.
- Prescaler equals r_presc on a qualified tick: it clears to 0 and issues a step.
- Otherwise it increments.
REQ-022 On a step, counter_o, valid_o=1 and end_o SHALL update on the same edge.
- valid_o and end_o are high for exactly one cycle.
- Latency: the step tick to visible valid_o is 1 clock.
REQ-023 Sawtooth step rules SHALL be:
- counter_o == r_end: next = r_start, end_o=1.
- Otherwise: next = counter_o+1.
REQ-024 Triangle step rules SHALL be:
- Up and counter_o == r_end: direction = down, next = counter_o-1.
- Down and counter_o == r_start: direction = up, next = counter_o+1.
- Otherwise: step in the current direction.
- end_o=1 on the step whose new counter_o equals r_start while counting down.
REQ-025 r_start == r_end SHALL hold counter_o at r_start with end_o=1 on every step, in both modes.
REQ-026 All arithmetic SHALL be modulo 2^NUM_BITS, with equality compares only.
- r_start > r_end wraps through all-ones/zero and is not an error.
REQ-027 With ctrl_active_i low, the following SHALL hold:
- counter_o, direction and prescaler hold.
- valid_o=0 and end_o=0.
- ctrl_rst_i and ctrl_update_i still act.
REQ-028 sawtooth_o SHALL equal r_sawtooth.
REQ-029 No valid_o SHALL be issued on a ctrl_rst_i or ctrl_update_i cycle, even if a qualified tick is present.

Reset
REQ-030 rst_i SHALL clear the following to 0:
- counter_o, valid_o, end_o.
- All shadow regs, so sawtooth_o=0.
- Prescaler.
- Direction (0 = up).
REQ-031 rst_i asserted mid-period SHALL abort the period; the next step follows the REQ-023/024 rules from 0.

Configuration
REQ-032 Macro TIMER_COUNTER_PRESC_EN defined: cfg_presc_i and the prescaler SHALL be implemented per REQ-021.
REQ-033 Macro TIMER_COUNTER_PRESC_EN undefined: the prescaler SHALL be removed, every qualified tick is a step, and cfg_presc_i is ignored.

Verification
REQ-034 Sawtooth, NUM_BITS=16, start=2, end=5, presc=0, tick_i held high -> counter_o 3,4,5,2,3,...; end_o with counter_o=2; valid_o every cycle.
REQ-035 Triangle, start=0, end=3, presc=0 -> counter_o 1,2,3,2,1,0,1,...; end_o only with the 0 reached counting down.
REQ-036 With PRESC_EN, presc=2, tick_i always high -> valid_o every 3rd cycle. Without PRESC_EN, same stimulus -> valid_o every cycle.
REQ-037 Counting at 4 with ctrl_rst_i and tick_i both high -> counter_o=start next cycle, valid_o=0. ctrl_active_i low for 10 cycles -> counter_o frozen, no pulses.
REQ-038 start=0xFFFE, end=0x0001, sawtooth -> counter_o FFFF,0000,0001,FFFE; end_o on FFFE. start=end=7 -> counter_o stays 7, end_o every step.

Source files
------------

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - prescaled sawtooth/triangle period counter with shadowed configuration
//
// Optional feature macro: TIMER_COUNTER_PRESC_EN (tick prescaler; without it every qualified tick steps)
//
// Ports:
//   clk_i           clock, all state updates on the rising edge
//   rst_i           synchronous active-high reset
//   ctrl_active_i   counting enable; low freezes counter, direction and prescaler
//   ctrl_update_i   load shadow config from cfg_* and restart the count
//   ctrl_rst_i      restart the count with the current shadow config
//   tick_i          input event, one credit per high cycle
//   cfg_start_i     period start value
//   cfg_end_i       period end value
//   cfg_presc_i     ticks per step minus one
//   cfg_sawtooth_i  1 = sawtooth, 0 = up/down triangle
//   counter_o       current count
//   valid_o         one-cycle pulse, counter_o just stepped
//   end_o           one-cycle pulse with valid_o at the period boundary
//   sawtooth_o      registered mode bit
module timer_counter #(
    parameter int NUM_BITS   = 16,
    parameter int PRESC_BITS = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ctrl_active_i,
    input  logic                  ctrl_update_i,
    input  logic                  ctrl_rst_i,
    input  logic                  tick_i,
    input  logic [NUM_BITS-1:0]   cfg_start_i,
    input  logic [NUM_BITS-1:0]   cfg_end_i,
    input  logic [PRESC_BITS-1:0] cfg_presc_i,
    input  logic                  cfg_sawtooth_i,
    output logic [NUM_BITS-1:0]   counter_o,
    output logic                  valid_o,
    output logic                  end_o,
    output logic                  sawtooth_o
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [NUM_BITS-1:0] CNT_ONE = NUM_BITS'(1);

    logic [NUM_BITS-1:0] counter_q, counter_d;
    logic [NUM_BITS-1:0] r_start_q, r_start_d;
    logic [NUM_BITS-1:0] r_end_q, r_end_d;
    logic                r_sawtooth_q, r_sawtooth_d;
    dir_e                dir_q, dir_d;
    logic                valid_q, valid_d;
    logic                end_q, end_d;

    logic                qual_tick;
    logic                step;
    logic [NUM_BITS-1:0] cnt_inc;
    logic [NUM_BITS-1:0] cnt_dec;

    assign qual_tick = ctrl_active_i & tick_i;
    assign cnt_inc   = counter_q + CNT_ONE;
    assign cnt_dec   = counter_q - CNT_ONE;

`ifdef TIMER_COUNTER_PRESC_EN
    localparam logic [PRESC_BITS-1:0] PRESC_ONE = PRESC_BITS'(1);

    logic [PRESC_BITS-1:0] presc_q, presc_d;
    logic [PRESC_BITS-1:0] r_presc_q, r_presc_d;

    // Restart/update clear the prescaler so a fresh period always begins
    // with a full r_presc+1 tick interval.
    always_comb begin
        presc_d   = presc_q;
        r_presc_d = r_presc_q;
        step      = 1'b0;
        if (ctrl_rst_i) begin
            presc_d = '0;
        end else if (ctrl_update_i) begin
            presc_d   = '0;
            r_presc_d = cfg_presc_i;
        end else if (qual_tick) begin
            if (presc_q == r_presc_q) begin
                presc_d = '0;
                step    = 1'b1;
            end else begin
                presc_d = presc_q + PRESC_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q   <= '0;
            r_presc_q <= '0;
        end else begin
            presc_q   <= presc_d;
            r_presc_q <= r_presc_d;
        end
    end
`else
    logic unused_presc;

    assign unused_presc = ^cfg_presc_i;
    assign step         = qual_tick;
`endif

    always_comb begin
        counter_d    = counter_q;
        dir_d        = dir_q;
        r_start_d    = r_start_q;
        r_end_d      = r_end_q;
        r_sawtooth_d = r_sawtooth_q;
        valid_d      = 1'b0;
        end_d        = 1'b0;
        if (ctrl_rst_i) begin
            counter_d = r_start_q;
            dir_d     = DIR_UP;
        end else if (ctrl_update_i) begin
            r_start_d    = cfg_start_i;
            r_end_d      = cfg_end_i;
            r_sawtooth_d = cfg_sawtooth_i;
            counter_d    = cfg_start_i;
            dir_d        = DIR_UP;
        end else if (step) begin
            valid_d = 1'b1;
            if (r_start_q == r_end_q) begin
                // Degenerate period: pin at start, every step is a boundary.
                counter_d = r_start_q;
                end_d     = 1'b1;
            end else if (r_sawtooth_q) begin
                if (counter_q == r_end_q) begin
                    counter_d = r_start_q;
                    end_d     = 1'b1;
                end else begin
                    counter_d = cnt_inc;
                end
            end else if (dir_q == DIR_UP) begin
                if (counter_q == r_end_q) begin
                    // Turning at end; with end == start+1 this step lands on start.
                    dir_d     = DIR_DOWN;
                    counter_d = cnt_dec;
                    end_d     = (cnt_dec == r_start_q);
                end else begin
                    counter_d = cnt_inc;
                end
            end else begin
                if (counter_q == r_start_q) begin
                    dir_d     = DIR_UP;
                    counter_d = cnt_inc;
                end else begin
                    counter_d = cnt_dec;
                    end_d     = (cnt_dec == r_start_q);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            counter_q    <= '0;
            dir_q        <= DIR_UP;
            r_start_q    <= '0;
            r_end_q      <= '0;
            r_sawtooth_q <= 1'b0;
            valid_q      <= 1'b0;
            end_q        <= 1'b0;
        end else begin
            counter_q    <= counter_d;
            dir_q        <= dir_d;
            r_start_q    <= r_start_d;
            r_end_q      <= r_end_d;
            r_sawtooth_q <= r_sawtooth_d;
            valid_q      <= valid_d;
            end_q        <= end_d;
        end
    end

    assign counter_o  = counter_q;
    assign valid_o    = valid_q;
    assign end_o      = end_q;
    assign sawtooth_o = r_sawtooth_q;

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - scoreboard bench for timer_counter against a period-position model
module tb_timer_counter;

    localparam int NB   = 16;
    localparam int PB   = 8;
    localparam int MASK = 32'h0000_FFFF;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          ctrl_active_i;
    logic          ctrl_update_i;
    logic          ctrl_rst_i;
    logic          tick_i;
    logic [NB-1:0] cfg_start_i;
    logic [NB-1:0] cfg_end_i;
    logic [PB-1:0] cfg_presc_i;
    logic          cfg_sawtooth_i;
    logic [NB-1:0] counter_o;
    logic          valid_o;
    logic          end_o;
    logic          sawtooth_o;

    timer_counter #(.NUM_BITS(NB), .PRESC_BITS(PB)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ctrl_active_i  (ctrl_active_i),
        .ctrl_update_i  (ctrl_update_i),
        .ctrl_rst_i     (ctrl_rst_i),
        .tick_i         (tick_i),
        .cfg_start_i    (cfg_start_i),
        .cfg_end_i      (cfg_end_i),
        .cfg_presc_i    (cfg_presc_i),
        .cfg_sawtooth_i (cfg_sawtooth_i),
        .counter_o      (counter_o),
        .valid_o        (valid_o),
        .end_o          (end_o),
        .sawtooth_o     (sawtooth_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int stamp;
        int cnt;
        bit endp;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Model: the period is a list of positions 0..len-1; the counter is the
    // value at the current position and a boundary is re-entering position 0.
    int m_start, m_end, m_presc, m_pos, m_pc, m_cnt;
    bit m_saw;

    function automatic int pos_value(int p);
        int l;
        l = (m_end - m_start) & MASK;
        if (m_saw || p <= l) return (m_start + p) & MASK;
        return (m_start + 2 * l - p) & MASK;
    endfunction

    task automatic model_apply(bit rst, bit crst, bit upd, bit act, bit tk,
                               int st, int en, int pr, bit sw);
        bit   stp;
        int   l;
        int   len;
        exp_t e;
        stp = 1'b0;
        if (rst) begin
            m_start = 0; m_end = 0; m_presc = 0; m_saw = 0;
            m_pos = 0; m_pc = 0; m_cnt = 0;
        end else if (crst) begin
            m_pos = 0; m_pc = 0; m_cnt = m_start;
        end else if (upd) begin
            m_start = st; m_end = en; m_presc = pr; m_saw = sw;
            m_pos = 0; m_pc = 0; m_cnt = st;
        end else if (act && tk) begin
`ifdef TIMER_COUNTER_PRESC_EN
            m_pc = m_pc + 1;
            stp  = (m_pc > m_presc);
            if (stp) m_pc = 0;
`else
            stp = 1'b1;
`endif
        end
        if (stp) begin
            l     = (m_end - m_start) & MASK;
            len   = m_saw ? l + 1 : ((l == 0) ? 1 : 2 * l);
            m_pos = (m_pos + 1) % len;
            m_cnt = pos_value(m_pos);
            e.stamp = cyc + 1;
            e.cnt   = m_cnt;
            e.endp  = (m_pos == 0);
            exp_q.push_back(e);
        end
    endtask

    // Called at a falling edge: check state left by the last rising edge,
    // then present the next inputs and advance the model.
    task automatic do_cycle(bit rst, bit crst, bit upd, bit act, bit tk,
                            int st, int en, int pr, bit sw);
        n_vec++;
        if (counter_o !== m_cnt[NB-1:0]) begin
            n_fail++;
            $display("FAIL counter cyc=%0d actual=%h required=%h", cyc, counter_o, m_cnt[NB-1:0]);
        end
        n_vec++;
        if (sawtooth_o !== m_saw) begin
            n_fail++;
            $display("FAIL sawtooth_o cyc=%0d actual=%b required=%b", cyc, sawtooth_o, m_saw);
        end
        rst_i          = rst;
        ctrl_rst_i     = crst;
        ctrl_update_i  = upd;
        ctrl_active_i  = act;
        tick_i         = tk;
        cfg_start_i    = st[NB-1:0];
        cfg_end_i      = en[NB-1:0];
        cfg_presc_i    = pr[PB-1:0];
        cfg_sawtooth_i = sw;
        model_apply(rst, crst, upd, act, tk, st, en, pr, sw);
        @(negedge clk_i);
    endtask

    task automatic run_cfg(int st, int en, int pr, bit sw, int n);
        do_cycle(0, 0, 1, 1, 1, st, en, pr, sw);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 1, 1, 16'h5A5A, 16'hA5A5, 0, ~sw);
    endtask

    // Monitor: pops one expectation per valid_o pulse and flags pulses that
    // arrive without one, or expectations whose cycle passes with no pulse.
    always @(negedge clk_i) begin
        exp_t e;
        if (valid_o === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0 || exp_q[0].stamp != cyc) begin
                n_fail++;
                $display("FAIL unexpected_valid cyc=%0d actual=1 required=0", cyc);
            end else begin
                e = exp_q.pop_front();
                n_vec++;
                if (counter_o !== e.cnt[NB-1:0] || end_o !== e.endp) begin
                    n_fail++;
                    $display("FAIL step cyc=%0d actual cnt=%h end=%b required cnt=%h end=%b",
                             cyc, counter_o, end_o, e.cnt[NB-1:0], e.endp);
                end
            end
        end else begin
            if (exp_q.size() > 0 && exp_q[0].stamp == cyc) begin
                n_vec++;
                n_fail++;
                e = exp_q.pop_front();
                $display("FAIL missing_valid cyc=%0d actual=%b required=1 cnt=%h", cyc, valid_o, e.cnt[NB-1:0]);
            end
            if (end_o !== 1'b0) begin
                n_vec++;
                n_fail++;
                $display("FAIL end_without_valid cyc=%0d actual=%b required=0", cyc, end_o);
            end
        end
    end

    initial begin
        int st, en, pr;
        bit sw;
        rst_i = 1; ctrl_rst_i = 0; ctrl_update_i = 0; ctrl_active_i = 0; tick_i = 0;
        cfg_start_i = '0; cfg_end_i = '0; cfg_presc_i = '0; cfg_sawtooth_i = 0;
        model_apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        do_cycle(1, 0, 0, 1, 1, 0, 0, 0, 0);
        // Directed periods: sawtooth, triangle, prescaled, wrap, degenerate.
        run_cfg(2, 5, 0, 1, 12);
        run_cfg(0, 3, 0, 0, 14);
        run_cfg(0, 3, 2, 1, 12);
        run_cfg(16'hFFFE, 16'h0001, 0, 1, 10);
        run_cfg(7, 7, 0, 0, 5);
        run_cfg(7, 7, 1, 1, 5);
        run_cfg(4, 5, 0, 0, 8);
        // Restart at count 4 with a coincident tick, then freeze.
        run_cfg(0, 7, 0, 0, 4);
        do_cycle(0, 1, 0, 1, 1, 3, 9, 0, 1);
        for (int i = 0; i < 10; i++) do_cycle(0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) do_cycle(0, 0, 0, 1, 1, 0, 0, 0, 0);
        // Update coincident with tick: restart without a pulse.
        do_cycle(0, 0, 1, 1, 1, 20, 22, 1, 0);
        for (int i = 0; i < 6; i++) do_cycle(0, 0, 0, 1, 1, 0, 0, 0, 1);
        // Randomized periods with sporadic restarts, resets and idle cycles.
        for (int ph = 0; ph < 20; ph++) begin
            st = $urandom & MASK;
            en = (st + $urandom_range(0, 6)) & MASK;
            pr = $urandom_range(0, 3);
            sw = $urandom_range(0, 1);
            do_cycle(0, 0, 1, 1, $urandom_range(0, 1), st, en, pr, sw);
            for (int i = 0; i < 40; i++) begin
                do_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0, 0,
                         $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                         $urandom & MASK, $urandom & MASK, $urandom_range(0, 255),
                         $urandom_range(0, 1));
            end
        end
        for (int i = 0; i < 3; i++) do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expect actual=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
